memory_access: RTL and testbench

Pipeline MEM stage of the 5-stage MIPS-style core: consumes EX/MEM outputs from the execute stage, performs byte/halfword/word loads and stores against an internal data memory, resolves the branch decision, and registers results into the MEM/WB pipeline register. Also drives the MEM/WB forwarding value (`memory_mem_wb`) back to the execute stage.

---
 rtl/memory_access.sv | 120 ++++++++++++
 tb/tb_memory_access.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage pipeline. Holds the data memory,
// performs sized loads/stores, resolves the branch decision and registers
// results into the MEM/WB pipeline register.
module memory_access #(
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] result_in,
    input  logic [31:0] registro_2_in,
    input  logic [4:0]  reg_dest_in,
    input  logic [10:0] jump_dest_addr_in,
    input  logic        zero_signal_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic [2:0]  trunk_mode_in,
    output logic        pc_src_out,
    output logic [10:0] branch_target_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_dest_out,
    output logic        MemToReg_out,
    output logic        RegWrite_out,
    output logic [31:0] memory_mem_wb
);

    localparam int DEPTH = 1 << ADDR_W;

    // Access size/sign encodings; unlisted codes behave as word.
    localparam logic [2:0] MODE_HALF_S = 3'b001;
    localparam logic [2:0] MODE_HALF_U = 3'b010;
    localparam logic [2:0] MODE_BYTE_S = 3'b011;
    localparam logic [2:0] MODE_BYTE_U = 3'b100;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic [31:0]       rd_word;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_val;
    logic [31:0]       store_word;

    // Upper address bits above the word index are ignored, so addresses wrap.
    assign word_idx = result_in[ADDR_W+1:2];
    assign byte_off = result_in[1:0];
    assign rd_word  = mem[word_idx];

    assign pc_src_out        = Branch_in & zero_signal_in;
    assign branch_target_out = jump_dest_addr_in;
    assign memory_mem_wb     = MemToReg_out ? read_data_out : alu_result_out;

    // Select the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        byte_lane = rd_word[7:0];
        half_lane = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_val  = rd_word;
        case (byte_off)
            2'd0: byte_lane = rd_word[7:0];
            2'd1: byte_lane = rd_word[15:8];
            2'd2: byte_lane = rd_word[23:16];
            2'd3: byte_lane = rd_word[31:24];
        endcase
        case (trunk_mode_in)
            MODE_HALF_S: load_val = {{16{half_lane[15]}}, half_lane};
            MODE_HALF_U: load_val = {16'h0000, half_lane};
            MODE_BYTE_S: load_val = {{24{byte_lane[7]}}, byte_lane};
            MODE_BYTE_U: load_val = {24'h000000, byte_lane};
            default:     load_val = rd_word;
        endcase
    end

    // Merge the store data into the current word so untouched lanes keep their value.
    always_comb begin
        store_word = rd_word;
        case (trunk_mode_in)
            MODE_HALF_S, MODE_HALF_U: begin
                if (byte_off[1]) store_word[31:16] = registro_2_in[15:0];
                else             store_word[15:0]  = registro_2_in[15:0];
            end
            MODE_BYTE_S, MODE_BYTE_U: begin
                case (byte_off)
                    2'd0: store_word[7:0]   = registro_2_in[7:0];
                    2'd1: store_word[15:8]  = registro_2_in[7:0];
                    2'd2: store_word[23:16] = registro_2_in[7:0];
                    2'd3: store_word[31:24] = registro_2_in[7:0];
                endcase
            end
            default: store_word = registro_2_in;
        endcase
    end

    // Data memory write port; contents survive reset but writes are blocked during it.
    always_ff @(posedge clock) begin
        if (!reset && MemWrite_in) begin
            mem[word_idx] <= store_word;
        end
    end

    // MEM/WB pipeline register; a load sees the pre-store word when both strobes are set.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_data_out  <= 32'h0;
            alu_result_out <= 32'h0;
            reg_dest_out   <= 5'h0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
        end else begin
            read_data_out  <= MemRead_in ? load_val : 32'h0;
            alu_result_out <= result_in;
            reg_dest_out   <= reg_dest_in;
            MemToReg_out   <= MemToReg_in;
            RegWrite_out   <= RegWrite_in;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: byte-array reference model, directed spec cases
// and a randomized instruction stream.
module tb_memory_access;

    localparam int ADDR_W = 8;
    localparam int NBYTES = 4 * (1 << ADDR_W);

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] result_in, registro_2_in;
    logic [4:0]  reg_dest_in;
    logic [10:0] jump_dest_addr_in;
    logic        zero_signal_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
    logic [2:0]  trunk_mode_in;
    logic        pc_src_out;
    logic [10:0] branch_target_out;
    logic [31:0] read_data_out, alu_result_out, memory_mem_wb;
    logic [4:0]  reg_dest_out;
    logic        MemToReg_out, RegWrite_out;

    memory_access #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .result_in(result_in), .registro_2_in(registro_2_in),
        .reg_dest_in(reg_dest_in), .jump_dest_addr_in(jump_dest_addr_in),
        .zero_signal_in(zero_signal_in), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Branch_in(Branch_in),
        .trunk_mode_in(trunk_mode_in), .pc_src_out(pc_src_out),
        .branch_target_out(branch_target_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .reg_dest_out(reg_dest_out),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .memory_mem_wb(memory_mem_wb)
    );

    always #5 clock = ~clock;

    logic [7:0]  ref_mem [NBYTES];
    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_rd, exp_alu;
    logic [4:0]  exp_dst;
    logic        exp_m2r, exp_rw;

    function automatic int access_bytes(input logic [2:0] m);
        if (m == 3'd1 || m == 3'd2) return 2;
        if (m == 3'd3 || m == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
        int unsigned b = a % NBYTES;
        int unsigned n = access_bytes(m);
        int unsigned base = b - (b % n);
        longint unsigned v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + ref_mem[base + i];
        if ((m == 3'd1) && v >= 32768) v = v + 64'hFFFF0000;
        if ((m == 3'd3) && v >= 128)   v = v + 64'hFFFFFF00;
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
        int unsigned b = a % NBYTES;
        int unsigned n = access_bytes(m);
        int unsigned base = b - (b % n);
        logic [31:0] t = d;
        for (int i = 0; i < n; i++) begin
            ref_mem[base + i] = t[7:0];
            t = t >> 8;
        end
    endtask

    // Present one instruction, clock it in, update the model and the expected MEM/WB values.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                         input logic [2:0] m, input logic m2r, input logic rw, input logic [4:0] dst);
        result_in = a; registro_2_in = d; MemRead_in = rd; MemWrite_in = wr;
        trunk_mode_in = m; MemToReg_in = m2r; RegWrite_in = rw; reg_dest_in = dst;
        exp_rd  = rd ? ref_load(a, m) : 32'h0;
        exp_alu = a; exp_dst = dst; exp_m2r = m2r; exp_rw = rw;
        @(posedge clock);
        if (wr && !reset) ref_store(a, m, d);
        #1;
    endtask

    task automatic init_memory();
        for (int w = 0; w < (1 << ADDR_W); w++) issue(w * 4, $urandom, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd1);
    endtask

    task automatic test_reset();
        result_in = 32'h10; registro_2_in = 32'hDEADBEEF; MemWrite_in = 1'b1; MemRead_in = 1'b1;
        MemToReg_in = 1'b1; RegWrite_in = 1'b1; reg_dest_in = 5'd5; trunk_mode_in = 3'd0;
        Branch_in = 1'b1; zero_signal_in = 1'b1; reset = 1'b1;
        #1;
        checks++; if (pc_src_out !== 1'b1) $display("FAIL reset_pc_src: got %b expected 1", pc_src_out); else passed++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            checks++; if (read_data_out !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", read_data_out); else passed++;
            checks++; if (alu_result_out !== 32'h0) $display("FAIL reset_alu_result: got %h expected 0", alu_result_out); else passed++;
            checks++; if (reg_dest_out !== 5'h0) $display("FAIL reset_reg_dest: got %h expected 0", reg_dest_out); else passed++;
            checks++; if (MemToReg_out !== 1'b0) $display("FAIL reset_memtoreg: got %b expected 0", MemToReg_out); else passed++;
            checks++; if (RegWrite_out !== 1'b0) $display("FAIL reset_regwrite: got %b expected 0", RegWrite_out); else passed++;
            checks++; if (memory_mem_wb !== 32'h0) $display("FAIL reset_mem_wb: got %h expected 0", memory_mem_wb); else passed++;
        end
        reset = 1'b0; Branch_in = 1'b0; zero_signal_in = 1'b0;
        issue(32'h10, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd5);
        checks++; if (read_data_out !== exp_rd) $display("FAIL reset_store_dropped: got %h expected %h", read_data_out, exp_rd); else passed++;
        checks++; if (read_data_out === 32'hDEADBEEF) $display("FAIL reset_store_leaked: got %h expected not deadbeef", read_data_out); else passed++;
    endtask

    task automatic test_word();
        issue(32'h20, 32'h12345678, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 5'd0);
        checks++; if (read_data_out !== 32'h0) $display("FAIL sw_read_data: got %h expected 0", read_data_out); else passed++;
        issue(32'h20, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd7);
        checks++; if (read_data_out !== 32'h12345678) $display("FAIL lw_read_data: got %h expected 12345678", read_data_out); else passed++;
        checks++; if (memory_mem_wb !== 32'h12345678) $display("FAIL lw_mem_wb: got %h expected 12345678", memory_mem_wb); else passed++;
    endtask

    task automatic test_byte();
        issue(32'h21, 32'h123456AA, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 5'd0);
        issue(32'h20, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd2);
        checks++; if (read_data_out !== 32'h1234AA78) $display("FAIL sb_lw: got %h expected 1234aa78", read_data_out); else passed++;
        issue(32'h21, 32'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 5'd2);
        checks++; if (read_data_out !== 32'hFFFFFFAA) $display("FAIL lb: got %h expected ffffffaa", read_data_out); else passed++;
        issue(32'h21, 32'h0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 5'd2);
        checks++; if (read_data_out !== 32'h000000AA) $display("FAIL lbu: got %h expected 000000aa", read_data_out); else passed++;
    endtask

    task automatic test_half();
        issue(32'h22, 32'hABCD8001, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 5'd0);
        issue(32'h22, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 5'd3);
        checks++; if (read_data_out !== 32'hFFFF8001) $display("FAIL lh: got %h expected ffff8001", read_data_out); else passed++;
        issue(32'h23, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 5'd3);
        checks++; if (read_data_out !== 32'h00008001) $display("FAIL lhu: got %h expected 00008001", read_data_out); else passed++;
        issue(32'h20, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd3);
        checks++; if (read_data_out !== 32'h8001AA78) $display("FAIL sh_lw: got %h expected 8001aa78", read_data_out); else passed++;
    endtask

    task automatic test_branch();
        Branch_in = 1'b1; zero_signal_in = 1'b1; jump_dest_addr_in = 11'h155;
        #1;
        checks++; if (pc_src_out !== 1'b1) $display("FAIL branch_taken: got %b expected 1", pc_src_out); else passed++;
        checks++; if (branch_target_out !== 11'h155) $display("FAIL branch_target: got %h expected 155", branch_target_out); else passed++;
        zero_signal_in = 1'b0;
        #1;
        checks++; if (pc_src_out !== 1'b0) $display("FAIL branch_not_zero: got %b expected 0", pc_src_out); else passed++;
        Branch_in = 1'b0; zero_signal_in = 1'b1;
        #1;
        checks++; if (pc_src_out !== 1'b0) $display("FAIL branch_disabled: got %b expected 0", pc_src_out); else passed++;
        zero_signal_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(32'h40, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 5'd0);
        issue(32'h40, 32'h55, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 5'd4);
        checks++; if (read_data_out !== 32'h0) $display("FAIL rw_same_old: got %h expected 0", read_data_out); else passed++;
        issue(32'h40, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd4);
        checks++; if (read_data_out !== 32'h55) $display("FAIL rw_same_new: got %h expected 55", read_data_out); else passed++;
        issue(32'h40 + NBYTES, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd4);
        checks++; if (read_data_out !== 32'h55) $display("FAIL alias: got %h expected 55", read_data_out); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        br, zf;
        logic [10:0] tgt;
        for (int i = 0; i < 400; i++) begin
            br = 1'($urandom); zf = 1'($urandom); tgt = 11'($urandom);
            Branch_in = br; zero_signal_in = zf; jump_dest_addr_in = tgt;
            #1;
            checks++; if (pc_src_out !== (br && zf)) $display("FAIL rnd_pc_src[%0d]: got %b expected %b", i, pc_src_out, br && zf); else passed++;
            checks++; if (branch_target_out !== tgt) $display("FAIL rnd_target[%0d]: got %h expected %h", i, branch_target_out, tgt); else passed++;
            a = ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63);
            issue(a, $urandom, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 5'($urandom));
            checks++; if (read_data_out !== exp_rd) $display("FAIL rnd_read_data[%0d]: got %h expected %h", i, read_data_out, exp_rd); else passed++;
            checks++; if (alu_result_out !== exp_alu) $display("FAIL rnd_alu[%0d]: got %h expected %h", i, alu_result_out, exp_alu); else passed++;
            checks++; if (reg_dest_out !== exp_dst) $display("FAIL rnd_dst[%0d]: got %h expected %h", i, reg_dest_out, exp_dst); else passed++;
            checks++; if (MemToReg_out !== exp_m2r) $display("FAIL rnd_m2r[%0d]: got %b expected %b", i, MemToReg_out, exp_m2r); else passed++;
            checks++; if (RegWrite_out !== exp_rw) $display("FAIL rnd_rw[%0d]: got %b expected %b", i, RegWrite_out, exp_rw); else passed++;
            checks++;
            if (memory_mem_wb !== (exp_m2r ? exp_rd : exp_alu))
                $display("FAIL rnd_mem_wb[%0d]: got %h expected %h", i, memory_mem_wb, exp_m2r ? exp_rd : exp_alu);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; result_in = '0; registro_2_in = '0; reg_dest_in = '0; jump_dest_addr_in = '0;
        zero_signal_in = 1'b0; MemToReg_in = 1'b0; RegWrite_in = 1'b0; MemRead_in = 1'b0;
        MemWrite_in = 1'b0; Branch_in = 1'b0; trunk_mode_in = 3'd0;
        @(posedge clock); #1;
        reset = 1'b0;
        init_memory();
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_branch();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
